// File: rtl/sys_port_arbiter.sv
// Two-requester round-robin arbiter onto one cache port: IDLE grants, BUSY holds the access, RELEASE acks.
// Strobe one cycle after grant, ack one cycle after sys_ack; requests hold until ack, and a BUSY watchdog ends stalled accesses.
module sys_port_arbiter #(
    parameter int ADDR_WIDTH     = 16,
    parameter int WORD_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255,
    localparam int BVAL_WIDTH    = WORD_WIDTH / 8
) (
    input  logic                  cache_clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [WORD_WIDTH-1:0] m0_wdata,
    input  logic [BVAL_WIDTH-1:0] m0_bval,
    input  logic                  m0_rd,
    input  logic                  m0_wr,
    output logic [WORD_WIDTH-1:0] m0_rdata,
    output logic                  m0_ack,
    output logic                  m0_err,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [WORD_WIDTH-1:0] m1_wdata,
    input  logic [BVAL_WIDTH-1:0] m1_bval,
    input  logic                  m1_rd,
    input  logic                  m1_wr,
    output logic [WORD_WIDTH-1:0] m1_rdata,
    output logic                  m1_ack,
    output logic                  m1_err,
    output logic [ADDR_WIDTH-1:0] sys_addr,
    output logic [WORD_WIDTH-1:0] sys_wdata,
    output logic [BVAL_WIDTH-1:0] sys_bval,
    output logic                  sys_rd,
    output logic                  sys_wr,
    input  logic [WORD_WIDTH-1:0] sys_rdata,
    input  logic                  sys_ack,
    output logic                  grant
);

    typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t                state;
    logic [7:0]            cnt;
    logic                  last_grant;
    logic                  op_err;

    logic                  req0;
    logic                  req1;
    logic                  win;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [WORD_WIDTH-1:0] sel_wdata;
    logic [BVAL_WIDTH-1:0] sel_bval;
    logic                  sel_rd;
    logic                  sel_wr;

    assign req0      = m0_rd | m0_wr;
    assign req1      = m1_rd | m1_wr;
    // A lone requester always wins; a tie goes to whoever did not win last time.
    assign win       = (req0 && req1) ? ~last_grant : req1;
    assign sel_addr  = win ? m1_addr  : m0_addr;
    assign sel_wdata = win ? m1_wdata : m0_wdata;
    assign sel_bval  = win ? m1_bval  : m0_bval;
    assign sel_rd    = win ? m1_rd    : m0_rd;
    assign sel_wr    = win ? m1_wr    : m0_wr;

    always_ff @(posedge cache_clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= 1'b1;
            op_err     <= 1'b0;
            grant      <= 1'b0;
            sys_addr   <= '0;
            sys_wdata  <= '0;
            sys_bval   <= '0;
            sys_rd     <= 1'b0;
            sys_wr     <= 1'b0;
            m0_rdata   <= '0;
            m0_ack     <= 1'b0;
            m0_err     <= 1'b0;
            m1_rdata   <= '0;
            m1_ack     <= 1'b0;
            m1_err     <= 1'b0;
        end else begin
            m0_ack <= 1'b0;
            m0_err <= 1'b0;
            m1_ack <= 1'b0;
            m1_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        grant      <= win;
                        last_grant <= win;
                        sys_addr   <= sel_addr;
                        sys_wdata  <= sel_wdata;
                        sys_bval   <= sel_bval;
                        // rd+wr together is illegal: issue the write, flag the error on ack.
                        sys_wr     <= sel_wr;
                        sys_rd     <= sel_rd & ~sel_wr;
                        op_err     <= sel_rd & sel_wr;
                        cnt        <= '0;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (sys_ack) begin
                        state  <= RELEASE;
                        sys_rd <= 1'b0;
                        sys_wr <= 1'b0;
                        if (grant == 1'b0) begin
                            m0_ack <= 1'b1;
                            m0_err <= op_err;
                            if (sys_rd) m0_rdata <= sys_rdata;
                        end else begin
                            m1_ack <= 1'b1;
                            m1_err <= op_err;
                            if (sys_rd) m1_rdata <= sys_rdata;
                        end
                    end else if (cnt == TO_LAST) begin
                        state  <= RELEASE;
                        cnt    <= cnt + 8'd1;
                        sys_rd <= 1'b0;
                        sys_wr <= 1'b0;
                        if (grant == 1'b0) begin
                            m0_ack   <= 1'b1;
                            m0_err   <= 1'b1;
                            m0_rdata <= '0;
                        end else begin
                            m1_ack   <= 1'b1;
                            m1_err   <= 1'b1;
                            m1_rdata <= '0;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                RELEASE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sys_port_arbiter.sv
// Directed scoreboard bench for sys_port_arbiter: stimulus queues expected issues and acks, a negedge monitor checks them.
module tb_sys_port_arbiter;

    logic        clk;
    logic        rst;
    logic [15:0] m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic [3:0]  m0_bval, m1_bval;
    logic        m0_rd, m0_wr, m1_rd, m1_wr;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [15:0] sys_addr;
    logic [31:0] sys_wdata;
    logic [3:0]  sys_bval;
    logic        sys_rd, sys_wr;
    logic [31:0] sys_rdata;
    logic        sys_ack;
    logic        grant;

    logic        hit_ack;
    logic        stray;
    int          ack_lat;
    int          busy_cyc;

    int checks;
    int failures;

    typedef struct {
        logic        g;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  bval;
        logic        rd;
        logic        wr;
    } sys_exp_t;

    typedef struct {
        int          port;
        logic        err;
        logic        upd;
        logic [31:0] rdata;
        int          len;
    } ack_exp_t;

    sys_exp_t    sys_q[$];
    ack_exp_t    ack_q[$];
    sys_exp_t    se;
    ack_exp_t    ae;
    logic [31:0] exp_rd [2];
    logic        prev_strobe;
    int          strobe_len;

    assign sys_ack = hit_ack | stray;

    sys_port_arbiter #(.ADDR_WIDTH(16), .WORD_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
        .cache_clk(clk), .rst(rst),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_bval(m0_bval), .m0_rd(m0_rd), .m0_wr(m0_wr),
        .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_bval(m1_bval), .m1_rd(m1_rd), .m1_wr(m1_wr),
        .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
        .sys_addr(sys_addr), .sys_wdata(sys_wdata), .sys_bval(sys_bval),
        .sys_rd(sys_rd), .sys_wr(sys_wr), .sys_rdata(sys_rdata), .sys_ack(sys_ack),
        .grant(grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rd_for(input logic [15:0] a);
        if (a == 16'h0010) return 32'hDEADBEEF;
        return {16'hA5A5, a};
    endfunction

    task automatic exp_sys(input logic g, input logic [15:0] a, input logic [31:0] d,
                           input logic [3:0] b, input logic rd, input logic wr);
        sys_exp_t e;
        e.g = g; e.addr = a; e.wdata = d; e.bval = b; e.rd = rd; e.wr = wr;
        sys_q.push_back(e);
    endtask

    task automatic exp_ack(input int p, input logic err, input logic upd,
                           input logic [31:0] rdata, input int len);
        ack_exp_t e;
        e.port = p; e.err = err; e.upd = upd; e.rdata = rdata; e.len = len;
        ack_q.push_back(e);
    endtask

    task automatic do_req(input int p, input logic rd, input logic wr, input logic [15:0] a,
                          input logic [31:0] d, input logic [3:0] b, input bit hold);
        bit got;
        if (p == 0) begin
            m0_addr = a; m0_wdata = d; m0_bval = b; m0_rd = rd; m0_wr = wr;
        end else begin
            m1_addr = a; m1_wdata = d; m1_bval = b; m1_rd = rd; m1_wr = wr;
        end
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ((p == 0) ? m0_ack : m1_ack) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL ack_wait port=%0d: no ack within 100 cycles, expected one", p);
        end
        if (!hold) begin
            if (p == 0) begin m0_rd = 1'b0; m0_wr = 1'b0; end
            else        begin m1_rd = 1'b0; m1_wr = 1'b0; end
        end
    endtask

    // Cache model: acks after ack_lat strobe cycles (0 = never), data keyed by address.
    always @(negedge clk) begin
        if (!rst) begin
            busy_cyc = 0;
            hit_ack  = 1'b0;
        end else if (sys_rd || sys_wr) begin
            busy_cyc++;
            hit_ack   = (ack_lat != 0) && (busy_cyc == ack_lat);
            sys_rdata = rd_for(sys_addr);
        end else begin
            busy_cyc = 0;
            hit_ack  = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            prev_strobe = 1'b0;
        end else begin
            if ((sys_rd || sys_wr) && !prev_strobe) begin
                strobe_len = 0;
                if (sys_q.size() == 0) begin
                    chk("unexpected_issue", {sys_rd, sys_wr}, 2'b00);
                end else begin
                    se = sys_q.pop_front();
                    chk("issue_grant", grant, se.g);
                    chk("issue_addr", sys_addr, se.addr);
                    chk("issue_wdata", sys_wdata, se.wdata);
                    chk("issue_bval", sys_bval, se.bval);
                    chk("issue_rd_wr", {sys_rd, sys_wr}, {se.rd, se.wr});
                end
            end
            if (sys_rd || sys_wr) strobe_len++;
            if (m0_ack || m1_ack || m0_err || m1_err) begin
                if (ack_q.size() == 0) begin
                    chk("unexpected_ack", {m1_ack, m0_ack, m1_err, m0_err}, 4'h0);
                end else begin
                    ae = ack_q.pop_front();
                    chk("ack_port", {m1_ack, m0_ack}, (ae.port == 1) ? 2'b10 : 2'b01);
                    chk("ack_err", {m1_err, m0_err},
                        ae.err ? ((ae.port == 1) ? 2'b10 : 2'b01) : 2'b00);
                    if (ae.upd) exp_rd[ae.port] = ae.rdata;
                    chk("m0_rdata", m0_rdata, exp_rd[0]);
                    chk("m1_rdata", m1_rdata, exp_rd[1]);
                    chk("busy_len", strobe_len, ae.len);
                end
            end
            prev_strobe = sys_rd || sys_wr;
        end
    end

    initial begin
        bit seen;
        checks = 0; failures = 0;
        rst = 1'b0; stray = 1'b0; ack_lat = 0; sys_rdata = '0;
        hit_ack = 1'b0; busy_cyc = 0; prev_strobe = 1'b0; strobe_len = 0;
        exp_rd[0] = '0; exp_rd[1] = '0;
        m0_addr = '0; m0_wdata = '0; m0_bval = '0; m0_rd = 1'b0; m0_wr = 1'b0;
        m1_addr = '0; m1_wdata = '0; m1_bval = '0; m1_rd = 1'b0; m1_wr = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_sys", {sys_rd, sys_wr, sys_addr, sys_wdata, sys_bval}, 64'h0);
        chk("reset_flags", {grant, m0_ack, m0_err, m1_ack, m1_err}, 5'h0);
        chk("reset_rdata", {m0_rdata, m1_rdata}, 64'h0);
        rst = 1'b1;
        @(negedge clk);

        // Stray sys_ack while idle
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        repeat (2) @(negedge clk);
        chk("stray_idle", {sys_rd, sys_wr, m0_ack, m1_ack, m0_err, m1_err, grant}, 7'h0);

        // m0 read, cache acks on the third strobe cycle
        ack_lat = 3;
        exp_sys(1'b0, 16'h0010, 32'h0, 4'hF, 1'b1, 1'b0);
        exp_ack(0, 1'b0, 1'b1, 32'hDEADBEEF, 3);
        do_req(0, 1'b1, 1'b0, 16'h0010, 32'h0, 4'hF, 1'b0);
        @(negedge clk);

        // m1 read, single-cycle ack
        ack_lat = 1;
        exp_sys(1'b1, 16'h0200, 32'h0, 4'hF, 1'b1, 1'b0);
        exp_ack(1, 1'b0, 1'b1, 32'hA5A50200, 1);
        do_req(1, 1'b1, 1'b0, 16'h0200, 32'h0, 4'hF, 1'b0);
        @(negedge clk);

        // Both write continuously: alternation 0,1,0,1
        ack_lat = 2;
        exp_sys(1'b0, 16'h0100, 32'h11111111, 4'h1, 1'b0, 1'b1);
        exp_sys(1'b1, 16'h0104, 32'h22222222, 4'h3, 1'b0, 1'b1);
        exp_sys(1'b0, 16'h0108, 32'h33333333, 4'hC, 1'b0, 1'b1);
        exp_sys(1'b1, 16'h010C, 32'h44444444, 4'hF, 1'b0, 1'b1);
        exp_ack(0, 1'b0, 1'b0, 32'h0, 2);
        exp_ack(1, 1'b0, 1'b0, 32'h0, 2);
        exp_ack(0, 1'b0, 1'b0, 32'h0, 2);
        exp_ack(1, 1'b0, 1'b0, 32'h0, 2);
        fork
            begin
                do_req(0, 1'b0, 1'b1, 16'h0100, 32'h11111111, 4'h1, 1'b1);
                do_req(0, 1'b0, 1'b1, 16'h0108, 32'h33333333, 4'hC, 1'b0);
            end
            begin
                do_req(1, 1'b0, 1'b1, 16'h0104, 32'h22222222, 4'h3, 1'b1);
                do_req(1, 1'b0, 1'b1, 16'h010C, 32'h44444444, 4'hF, 1'b0);
            end
        join
        @(negedge clk);

        // m1 write never acked: timeout after 4 BUSY cycles, late sys_ack ignored
        ack_lat = 0;
        exp_sys(1'b1, 16'h0300, 32'h5A5A5A5A, 4'h6, 1'b0, 1'b1);
        exp_ack(1, 1'b1, 1'b1, 32'h0, 4);
        do_req(1, 1'b0, 1'b1, 16'h0300, 32'h5A5A5A5A, 4'h6, 1'b0);
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        repeat (2) @(negedge clk);
        chk("late_ack_ignored", {sys_rd, sys_wr, m0_ack, m1_ack}, 4'h0);

        // m0 rd+wr together: write only, err with ack, rdata untouched
        ack_lat = 2;
        exp_sys(1'b0, 16'h0040, 32'hCAFEF00D, 4'hF, 1'b0, 1'b1);
        exp_ack(0, 1'b1, 1'b0, 32'h0, 2);
        do_req(0, 1'b1, 1'b1, 16'h0040, 32'hCAFEF00D, 4'hF, 1'b0);
        @(negedge clk);

        // Reset in the middle of BUSY
        ack_lat = 0;
        exp_sys(1'b0, 16'h0500, 32'h0, 4'hF, 1'b1, 1'b0);
        m0_addr = 16'h0500; m0_wdata = '0; m0_bval = 4'hF; m0_rd = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sys_rd) begin
                seen = 1'b1;
                break;
            end
        end
        chk("rst_test_issued", seen, 1'b1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midbusy_rst_sys", {sys_rd, sys_wr, sys_addr, sys_wdata, sys_bval}, 64'h0);
        chk("midbusy_rst_flags", {grant, m0_ack, m0_err, m1_ack, m1_err}, 5'h0);
        chk("midbusy_rst_rdata", {m0_rdata, m1_rdata}, 64'h0);
        m0_rd = 1'b0;
        exp_rd[0] = '0; exp_rd[1] = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // After reset, simultaneous requests go to requester 0 first
        ack_lat = 1;
        exp_sys(1'b0, 16'h0600, 32'h0, 4'hF, 1'b1, 1'b0);
        exp_sys(1'b1, 16'h0604, 32'h0, 4'hF, 1'b1, 1'b0);
        exp_ack(0, 1'b0, 1'b1, 32'hA5A50600, 1);
        exp_ack(1, 1'b0, 1'b1, 32'hA5A50604, 1);
        fork
            do_req(0, 1'b1, 1'b0, 16'h0600, 32'h0, 4'hF, 1'b0);
            do_req(1, 1'b1, 1'b0, 16'h0604, 32'h0, 4'hF, 1'b0);
        join

        repeat (10) @(negedge clk);
        chk("sys_q_drained", sys_q.size(), 0);
        chk("ack_q_drained", ack_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
